// File: rtl/arm_ctrl_pkg.sv
// arm_ctrl_pkg: state codes, ALU/B-mux encodings and instruction-class
// fields shared by the ARM control FSM and its wait timer.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        S_F0   = 4'd1,
        S_F1   = 4'd2,
        S_F2   = 4'd3,
        S_DEC  = 4'd4,
        S_DP   = 4'd5,
        S_LSA  = 4'd6,
        S_LSR  = 4'd7,
        S_LSWB = 4'd8,
        S_LSMD = 4'd9,
        S_LSW  = 4'd10,
        S_BRL  = 4'd11,
        S_BR   = 4'd12
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_MOV = 4'b1101;

    localparam logic [1:0] B_SHIFT = 2'd0;
    localparam logic [1:0] B_FOUR  = 2'd1;
    localparam logic [1:0] B_MDR   = 2'd2;
    localparam logic [1:0] B_PC    = 2'd3;

    localparam logic [2:0] CLS_DP_REG = 3'b000;
    localparam logic [2:0] CLS_DP_IMM = 3'b001;
    localparam logic [2:0] CLS_LS_IMM = 3'b010;
    localparam logic [2:0] CLS_LS_REG = 3'b011;
    localparam logic [2:0] CLS_BR     = 3'b101;

    // Unrecognised classes and failed conditions fall back to the next fetch.
    function automatic state_t dec_next(input logic [2:0] cls, input logic bit4,
                                        input logic link, input logic pass);
        if (!pass)
            return S_F0;
        if (cls == CLS_DP_IMM || (cls == CLS_DP_REG && !bit4))
            return S_DP;
        if (cls == CLS_LS_IMM || cls == CLS_LS_REG)
            return S_LSA;
        if (cls == CLS_BR)
            return link ? S_BRL : S_BR;
        return S_F0;
    endfunction

endpackage

// File: rtl/mfc_wait_timer.sv
// mfc_wait_timer: counts cycles spent in a memory wait state without mfc and
// flags the cycle on which the wait must be abandoned.
module mfc_wait_timer #(
    parameter int MFC_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic mfc,
    output logic timeout
);

    logic [3:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= 4'd0;
        else if (clear)
            count <= 4'd0;
        else if (enable && !mfc)
            count <= count + 4'd1;
    end

    assign timeout = enable && !mfc && count == 4'(MFC_TIMEOUT - 1);

endmodule

// File: rtl/arm_control_fsm.sv
// arm_control_fsm: multi-cycle Moore control unit sequencing fetch, decode
// and execute for data-processing, word load/store and branch instructions.
module arm_control_fsm
    import arm_ctrl_pkg::*;
#(
    parameter int MFC_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir,
    input  logic        cond_pass,
    input  logic        mfc,
    output logic        ir_ld,
    output logic        pc_ld,
    output logic        mar_ld,
    output logic        mdr_ld,
    output logic        rf_ld,
    output logic        s_ld,
    output logic        mem_en,
    output logic        mem_rw,
    output logic [3:0]  alu_op,
    output logic        a_sel,
    output logic [1:0]  b_sel,
    output logic        mar_src,
    output logic        mdr_src,
    output logic        rd_lr,
    output logic        bus_err,
    output logic [3:0]  state
);

    state_t cur, nxt;
    logic in_wait, timeout, unused_ir;

    assign in_wait   = cur inside {S_F1, S_LSR, S_LSW};
    assign bus_err   = timeout;
    assign state     = cur;
    assign unused_ir = ^{ir[31:28], ir[19:5], ir[3:0]};

    // The counter is held clear outside wait states, so every wait starts at 0.
    mfc_wait_timer #(.MFC_TIMEOUT(MFC_TIMEOUT)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (!in_wait),
        .enable (in_wait),
        .mfc    (mfc),
        .timeout(timeout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cur <= S_RST;
        else
            cur <= nxt;
    end

    always_comb begin
        nxt     = cur;
        ir_ld   = 1'b0;
        pc_ld   = 1'b0;
        mar_ld  = 1'b0;
        mdr_ld  = 1'b0;
        rf_ld   = 1'b0;
        s_ld    = 1'b0;
        mem_en  = 1'b0;
        mem_rw  = 1'b0;
        alu_op  = 4'd0;
        a_sel   = 1'b0;
        b_sel   = B_SHIFT;
        mar_src = 1'b0;
        mdr_src = 1'b0;
        rd_lr   = 1'b0;
        case (cur)
            S_RST: nxt = S_F0;
            S_F0: begin
                mar_ld = 1'b1;
                pc_ld  = 1'b1;
                alu_op = ALU_ADD;
                a_sel  = 1'b1;
                b_sel  = B_FOUR;
                nxt    = S_F1;
            end
            S_F1, S_LSR: begin
                mem_en = 1'b1;
                mem_rw = 1'b1;
                mdr_ld = 1'b1;
                nxt    = mfc ? (cur == S_F1 ? S_F2 : S_LSWB) : timeout ? S_F0 : cur;
            end
            S_F2: begin
                ir_ld = 1'b1;
                nxt   = S_DEC;
            end
            S_DEC: nxt = dec_next(ir[27:25], ir[4], ir[24], cond_pass);
            S_DP: begin
                alu_op = ir[24:21];
                s_ld   = ir[20];
                rf_ld  = ir[24:23] != 2'b10;
                nxt    = S_F0;
            end
            S_LSA: begin
                mar_ld  = 1'b1;
                mar_src = 1'b1;
                alu_op  = ir[23] ? ALU_ADD : ALU_SUB;
                nxt     = ir[20] ? S_LSR : S_LSMD;
            end
            S_LSWB: begin
                rf_ld  = 1'b1;
                alu_op = ALU_MOV;
                b_sel  = B_MDR;
                nxt    = S_F0;
            end
            S_LSMD: begin
                mdr_ld  = 1'b1;
                mdr_src = 1'b1;
                nxt     = S_LSW;
            end
            S_LSW: begin
                mem_en = 1'b1;
                nxt    = (mfc || timeout) ? S_F0 : S_LSW;
            end
            S_BRL: begin
                rf_ld  = 1'b1;
                rd_lr  = 1'b1;
                alu_op = ALU_MOV;
                b_sel  = B_PC;
                nxt    = S_BR;
            end
            S_BR: begin
                pc_ld  = 1'b1;
                alu_op = ALU_ADD;
                a_sel  = 1'b1;
                nxt    = S_F0;
            end
            default: nxt = S_RST;
        endcase
    end

endmodule

// File: tb/tb_arm_control_fsm.sv
// tb_arm_control_fsm: directed instruction table with cycle/bus_err counts,
// hand-written reset sequences, and random instruction streams checked per cycle.
module tb_arm_control_fsm;

    localparam int T = 15;
    localparam logic [3:0] RST = 0, F0 = 1, F1 = 2, F2 = 3, DEC = 4, DP = 5, LSA = 6,
                           LSR = 7, LSWB = 8, LSMD = 9, LSW = 10, BRL = 11, BR = 12;

    logic clk = 0, reset = 1, cond_pass = 0, mfc = 0;
    logic [31:0] ir = 0;
    logic ir_ld, pc_ld, mar_ld, mdr_ld, rf_ld, s_ld, mem_en, mem_rw;
    logic a_sel, mar_src, mdr_src, rd_lr, bus_err;
    logic [3:0] alu_op, state;
    logic [1:0] b_sel;
    logic [17:0] dut_outs;

    int cmp = 0, fail = 0;

    always #5 clk = ~clk;

    arm_control_fsm #(.MFC_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .ir(ir), .cond_pass(cond_pass), .mfc(mfc),
        .ir_ld(ir_ld), .pc_ld(pc_ld), .mar_ld(mar_ld), .mdr_ld(mdr_ld),
        .rf_ld(rf_ld), .s_ld(s_ld), .mem_en(mem_en), .mem_rw(mem_rw),
        .alu_op(alu_op), .a_sel(a_sel), .b_sel(b_sel), .mar_src(mar_src),
        .mdr_src(mdr_src), .rd_lr(rd_lr), .bus_err(bus_err), .state(state)
    );

    assign dut_outs = {ir_ld, pc_ld, mar_ld, mdr_ld, rf_ld, s_ld, mem_en, mem_rw,
                       alu_op, a_sel, b_sel, mar_src, mdr_src, rd_lr};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Strobes each state should show, straight from the per-state output list.
    function automatic logic [17:0] exp_outs(input logic [3:0] st, input logic [31:0] i);
        logic irl = 0, pcl = 0, marl = 0, mdrl = 0, rfl = 0, sl = 0, men = 0, mrw = 0;
        logic asl = 0, ms = 0, ds = 0, lr = 0;
        logic [3:0] op = 0;
        logic [1:0] bs = 0;
        case (st)
            F0: begin marl = 1; pcl = 1; op = 4'b0100; asl = 1; bs = 1; end
            F1, LSR: begin men = 1; mrw = 1; mdrl = 1; end
            F2: irl = 1;
            DP: begin op = i[24:21]; sl = i[20]; rfl = (i[24:23] != 2'b10); end
            LSA: begin marl = 1; ms = 1; op = i[23] ? 4'b0100 : 4'b0010; end
            LSWB: begin rfl = 1; op = 4'b1101; bs = 2; end
            LSMD: begin mdrl = 1; ds = 1; end
            LSW: men = 1;
            BRL: begin rfl = 1; lr = 1; op = 4'b1101; bs = 3; end
            BR: begin pcl = 1; op = 4'b0100; asl = 1; end
            default: ;
        endcase
        return {irl, pcl, marl, mdrl, rfl, sl, men, mrw, op, asl, bs, ms, ds, lr};
    endfunction

    typedef struct {
        logic [3:0] st;
        logic m;
        logic err;
        logic [31:0] ir;
        logic cond;
    } step_t;
    step_t tr[$];

    function automatic void put(input logic [3:0] st, input logic [31:0] i, input logic c);
        tr.push_back('{st, 1'($urandom % 2), 1'b0, i, c});
    endfunction

    // A wait whose mfc comes after d idle cycles; returns 0 if it times out.
    function automatic bit put_wait(input logic [3:0] st, input int d,
                                    input logic [31:0] i, input logic c);
        for (int k = 0; k < T; k++) begin
            if (k == d) begin
                tr.push_back('{st, 1'b1, 1'b0, i, c});
                return 1;
            end
            tr.push_back('{st, 1'b0, 1'(k == T - 1), i, c});
        end
        return 0;
    endfunction

    // Expected per-cycle trace of one instruction, from fetch to the next fetch.
    function automatic void gen(input logic [31:0] i, input logic c, input int d1, input int d2);
        logic [2:0] cls = i[27:25];
        put(F0, i, c);
        if (!put_wait(F1, d1, i, c)) return;
        put(F2, i, c);
        put(DEC, i, c);
        if (!c) return;
        if (cls == 3'b001 || (cls == 3'b000 && !i[4])) put(DP, i, c);
        else if (cls == 3'b010 || cls == 3'b011) begin
            put(LSA, i, c);
            if (i[20]) begin
                if (put_wait(LSR, d2, i, c)) put(LSWB, i, c);
            end else begin
                put(LSMD, i, c);
                void'(put_wait(LSW, d2, i, c));
            end
        end else if (cls == 3'b101) begin
            if (i[24]) put(BRL, i, c);
            put(BR, i, c);
        end
    endfunction

    function automatic int rand_delay();
        int r = $urandom_range(0, 9);
        return r < 6 ? r % 3 : r == 6 ? 13 : r == 7 ? 14 : r == 8 ? 15 : 30;
    endfunction

    function automatic logic [31:0] rand_ir();
        logic [31:0] i = $urandom;
        int sel = $urandom_range(0, 9);
        case (sel)
            0, 1: i[27:25] = 3'b001;
            2: begin i[27:25] = 3'b000; i[4] = 0; end
            3, 4: i[27:25] = 3'b010;
            5: i[27:25] = 3'b011;
            6, 7: i[27:25] = 3'b101;
            8: i[27:25] = ($urandom % 3 == 0) ? 3'b100 : ($urandom % 2 ? 3'b110 : 3'b111);
            default: begin i[27:25] = 3'b000; i[4] = 1; end
        endcase
        return i;
    endfunction

    typedef struct {
        logic [31:0] ir;
        logic cond;
        int d1, d2, cyc, errs;
    } vec_t;

    // Drives mfc after d idle cycles of each wait; counts cycles until the next F0.
    task automatic run_vec(input int n, input vec_t v);
        int cyc = 0, w = 0, errs = 0, d;
        logic [3:0] prev;
        chk($sformatf("vec%0d start", n), state, F0);
        do begin
            ir = v.ir;
            cond_pass = v.cond;
            d = (state == F1) ? v.d1 : v.d2;
            mfc = (state == F1 || state == LSR || state == LSW) ? 1'(w == d) : 1'($urandom % 2);
            #1;
            errs += int'(bus_err);
            prev = state;
            cyc++;
            @(negedge clk);
            w = (state == prev) ? w + 1 : 0;
        end while (state != F0 && cyc < 100);
        chk($sformatf("vec%0d cycles", n), cyc, v.cyc);
        chk($sformatf("vec%0d bus_err", n), errs, v.errs);
    endtask

    vec_t vt[13];

    initial begin
        vt[0]  = '{32'hE2821003, 1, 0, 0, 5, 0};   // ADD
        vt[1]  = '{32'hE1510002, 1, 0, 0, 5, 0};   // CMP
        vt[2]  = '{32'hE5921004, 1, 0, 2, 9, 0};   // LDR, LSR held 3 cycles
        vt[3]  = '{32'hEB000002, 1, 0, 0, 6, 0};   // BL
        vt[4]  = '{32'hEB000002, 0, 0, 0, 4, 0};   // BL, condition fails
        vt[5]  = '{32'hEA000002, 1, 0, 0, 5, 0};   // B
        vt[6]  = '{32'hE5821004, 1, 0, 99, 21, 1}; // STR, no mfc
        vt[7]  = '{32'hE5821004, 1, 0, 14, 21, 0}; // STR, mfc on 15th LSW cycle
        vt[8]  = '{32'hE2821003, 1, 99, 0, 16, 1}; // fetch timeout
        vt[9]  = '{32'hE2821003, 1, 14, 0, 19, 0}; // fetch mfc on last cycle
        vt[10] = '{32'hE8BD0003, 1, 0, 0, 4, 0};   // class 100: NOP
        vt[11] = '{32'hE0010291, 1, 0, 0, 4, 0};   // 000 with bit4: NOP
        vt[12] = '{32'hE7921003, 1, 0, 0, 7, 0};   // LDR register offset

        repeat (2) @(negedge clk);
        chk("reset state", state, RST);
        chk("reset outs", {dut_outs, bus_err}, 0);
        reset = 0;
        @(negedge clk);
        chk("first F0", state, F0);

        foreach (vt[k]) run_vec(k, vt[k]);

        // Reset in the middle of a fetch wait.
        ir = 32'hE2821003; cond_pass = 1; mfc = 0;
        @(negedge clk);
        chk("pre-reset F1", state, F1);
        #1 reset = 1;
        #1;
        chk("async reset state", state, RST);
        chk("async reset outs", {dut_outs, bus_err}, 0);
        @(negedge clk);
        mfc = 1;
        #1;
        chk("held reset outs", {state, dut_outs, bus_err}, 0);
        reset = 0;
        @(negedge clk);
        chk("F0 after reset", state, F0);

        // Random instruction stream against the trace model.
        for (int n = 0; n < 250; n++) begin
            tr.delete();
            gen(rand_ir(), 1'($urandom_range(0, 4) != 0), rand_delay(), rand_delay());
            foreach (tr[k]) begin
                ir = tr[k].ir;
                cond_pass = tr[k].cond;
                mfc = tr[k].m;
                #1;
                cmp++;
                if ({state, dut_outs, bus_err} !== {tr[k].st, exp_outs(tr[k].st, tr[k].ir), tr[k].err}) begin
                    fail++;
                    $display("FAIL rand%0d step%0d ir=%h: got st=%0d outs=%h err=%b expected st=%0d outs=%h err=%b",
                             n, k, tr[k].ir, state, dut_outs, bus_err,
                             tr[k].st, exp_outs(tr[k].st, tr[k].ir), tr[k].err);
                end
                @(negedge clk);
            end
        end
        chk("random end F0", state, F0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fail);
        $finish;
    end

endmodule
